// File: rtl/rvh_noc_pkg.sv
// Shared NoC definitions: flit header width and field layout.
//   FLIT_W             : flit header width (33)
//   QOS_VALUE_WIDTH    : QoS field width, bits [3:0]
//   OUTPUT_PORT_NUMBER : router output ports; sizes look-ahead route, bits [6:4]
package rvh_noc_pkg;

  localparam int unsigned FLIT_W             = 33;
  localparam int unsigned QOS_VALUE_WIDTH    = 4;
  localparam int unsigned OUTPUT_PORT_NUMBER = 6;
  localparam int unsigned LA_ROUTE_W         = $clog2(OUTPUT_PORT_NUMBER);
  localparam int unsigned PAYLOAD_W          = FLIT_W - LA_ROUTE_W - QOS_VALUE_WIDTH;

  // Header layout, LSB first: qos_value [3:0], look_ahead_routing [6:4], payload above.
  typedef struct packed {
    logic [PAYLOAD_W-1:0]       payload;
    logic [LA_ROUTE_W-1:0]      look_ahead_routing;
    logic [QOS_VALUE_WIDTH-1:0] qos_value;
  } flit_t;

endpackage

// File: rtl/vc_fifo.sv
// Single-VC circular flit FIFO. Pushes and pops arrive pre-qualified by the
// parent (no push when full without a pop, no pop when empty).
//   clk, rstn          : clock, synchronous active-high reset
//   i_push / i_data    : store i_data at the write pointer
//   i_pop              : retire the head entry
//   o_head_c           : head entry, read combinationally from storage
//   o_count            : current occupancy (registered)
//   o_full_c/o_empty_c : occupancy decodes
module vc_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 33,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head_c,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full_c,
  output logic              o_empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;

  // Explicit wrap so non-power-of-2 depths never index past the last slot.
  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (i_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/input_port_vc_buffer.sv
// Router input-port VC buffer: demuxes link flits into per-VC FIFOs, exposes
// each VC head to switch allocation, pops the granted VC and returns credits.
// Optional macro VC_BUF_ERR_CHECK_EN enables sticky overflow/underflow flags;
// without it both flags are tied low.
//   clk, rstn                      : clock, synchronous reset (active-high)
//   flit_vld_i/flit_i/flit_vc_id_i : incoming flit and its target VC
//   vc_ctrl_head_vld_o/_head_o     : per-VC non-empty and head flit
//   inport_read_enable_sa_stage_i  : SA pop request
//   inport_read_vc_id_oh_i         : one-hot VC to pop
//   credit_vld_o/credit_vc_id_o    : registered credit return
//   vc_occupancy_o                 : per-VC flit count
//   overflow_err_o/underflow_err_o : sticky error flags
module input_port_vc_buffer
  import rvh_noc_pkg::*;
#(
  parameter int unsigned VC_NUM   = 4,
  parameter int unsigned VC_DEPTH = 4,
  parameter int unsigned VC_ID_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     flit_vld_i,
  input  logic [FLIT_W-1:0]                        flit_i,
  input  logic [VC_ID_W-1:0]                       flit_vc_id_i,
  output logic [VC_NUM-1:0]                        vc_ctrl_head_vld_o,
  output logic [VC_NUM*FLIT_W-1:0]                 vc_ctrl_head_o,
  input  logic                                     inport_read_enable_sa_stage_i,
  input  logic [VC_NUM-1:0]                        inport_read_vc_id_oh_i,
  output logic                                     credit_vld_o,
  output logic [VC_ID_W-1:0]                       credit_vc_id_o,
  output logic [VC_NUM*$clog2(VC_DEPTH+1)-1:0]     vc_occupancy_o,
  output logic                                     overflow_err_o,
  output logic                                     underflow_err_o
);

  localparam int unsigned OCC_W = $clog2(VC_DEPTH + 1);

  logic [VC_NUM-1:0]  w_wr_hit;
  logic [VC_NUM-1:0]  w_push;
  logic [VC_NUM-1:0]  w_pop;
  logic [VC_NUM-1:0]  w_full;
  logic [VC_NUM-1:0]  w_empty;
  logic               w_vc_id_ok;
  logic               w_sel_onehot;
  logic [VC_ID_W-1:0] w_pop_idx;
  logic               r_credit_vld;
  logic [VC_ID_W-1:0] r_credit_vc_id;

  assign w_vc_id_ok   = (32'(flit_vc_id_i) < VC_NUM);
  assign w_sel_onehot = (inport_read_vc_id_oh_i != '0) &&
                        ((inport_read_vc_id_oh_i & (inport_read_vc_id_oh_i - VC_NUM'(1))) == '0);

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    assign w_wr_hit[g] = flit_vld_i && w_vc_id_ok && (flit_vc_id_i == VC_ID_W'(g));
    assign w_pop[g]    = inport_read_enable_sa_stage_i && w_sel_onehot &&
                         inport_read_vc_id_oh_i[g] && !w_empty[g];
    // A same-cycle pop frees the slot a full VC needs.
    assign w_push[g]   = w_wr_hit[g] && (!w_full[g] || w_pop[g]);
    assign vc_ctrl_head_vld_o[g] = !w_empty[g];

    vc_fifo #(
      .DEPTH  (VC_DEPTH),
      .DATA_W (FLIT_W),
      .CNT_W  (OCC_W)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .i_push    (w_push[g]),
      .i_data    (flit_i),
      .i_pop     (w_pop[g]),
      .o_head_c  (vc_ctrl_head_o[g*FLIT_W +: FLIT_W]),
      .o_count   (vc_occupancy_o[g*OCC_W +: OCC_W]),
      .o_full_c  (w_full[g]),
      .o_empty_c (w_empty[g])
    );
  end

  // One-hot to index for the credit VC id.
  always_comb begin
    w_pop_idx = '0;
    for (int unsigned k = 0; k < VC_NUM; k++) begin
      if (inport_read_vc_id_oh_i[k]) w_pop_idx = VC_ID_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_credit_vld   <= 1'b0;
      r_credit_vc_id <= '0;
    end else begin
      r_credit_vld <= |w_pop;
      if (|w_pop) r_credit_vc_id <= w_pop_idx;
    end
  end

  assign credit_vld_o   = r_credit_vld;
  assign credit_vc_id_o = r_credit_vc_id;

`ifdef VC_BUF_ERR_CHECK_EN
  logic w_ovf;
  logic w_udf;
  logic r_overflow_err;
  logic r_underflow_err;

  assign w_ovf = |(w_wr_hit & w_full & ~w_pop);
  assign w_udf = inport_read_enable_sa_stage_i &&
                 (!w_sel_onehot || |(inport_read_vc_id_oh_i & w_empty));

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (w_ovf) r_overflow_err  <= 1'b1;
      if (w_udf) r_underflow_err <= 1'b1;
    end
  end

  assign overflow_err_o  = r_overflow_err;
  assign underflow_err_o = r_underflow_err;
`else
  assign overflow_err_o  = 1'b0;
  assign underflow_err_o = 1'b0;
`endif

endmodule

// File: doc/input_port_vc_buffer.md
Name: input_port_vc_buffer

Overview:
- Per-input-port virtual-channel flit buffer of the NoC router; sits directly upstream of the local switch-allocation stage.
- Accepts flits from the link, one per cycle, tagged with a VC id, and stores them in per-VC FIFOs.
- Presents each VC's head flit and valid to local SA, and pops the granted VC when the SA read enable fires.
- Returns one credit per popped flit to the upstream router.

Parameters:
- VC_NUM, 4, number of virtual channels on this input port.
- VC_DEPTH, 4, flit slots per VC (any value >= 1; need not be a power of 2).
- VC_ID_W, (VC_NUM>1 ? $clog2(VC_NUM) : 1), VC index width.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; synchronous, active-high (asserted when 1) despite the name.
- flit_vld_i  input  1  incoming flit valid.
- flit_i  input  33  incoming flit header, rvh_noc_pkg layout.
- flit_vc_id_i  input  VC_ID_W  target VC of the incoming flit.
- vc_ctrl_head_vld_o  output  VC_NUM  per-VC non-empty.
- vc_ctrl_head_o  output  VC_NUM*33  per-VC head flit; VC i occupies bits [i*33 +: 33].
- inport_read_enable_sa_stage_i  input  1  SA pops one flit this cycle.
- inport_read_vc_id_oh_i  input  VC_NUM  one-hot VC to pop.
- credit_vld_o  output  1  credit return valid.
- credit_vc_id_o  output  VC_ID_W  VC of the returned credit.
- vc_occupancy_o  output  VC_NUM*($clog2(VC_DEPTH+1))  per-VC flit count.
- overflow_err_o  output  1  sticky error flag.
- underflow_err_o  output  1  sticky error flag.

Behaviour:
- Reset: all read/write pointers and counts = 0; vc_ctrl_head_vld_o = 0; credit_vld_o = 0; credit_vc_id_o = 0; error flags = 0; storage contents are not reset.
- Write: when flit_vld_i=1 and VC flit_vc_id_i count < VC_DEPTH, store flit_i at that VC's write pointer, advance the pointer and increment the count.
- Write latency: the flit is visible on the head outputs the cycle after the write (no same-cycle bypass).
- Head: vc_ctrl_head_o slice i = storage[i][rd_ptr[i]], read combinationally from registers. vc_ctrl_head_vld_o[i] = (count[i] != 0).
- Pop: when inport_read_enable_sa_stage_i=1, pop the VC selected by inport_read_vc_id_oh_i if that VC's count != 0. Advance the read pointer and decrement the count.
- Pointer wrap: pointers wrap from VC_DEPTH-1 to 0; non-power-of-2 depth uses an explicit compare, not natural overflow.
- Simultaneous write and pop, same VC: both take effect; the count is unchanged.
- Simultaneous write and pop, same VC, VC full: the pop frees a slot in the same cycle, so the write is accepted.
- Simultaneous write and pop, same VC, VC empty: the pop is an underflow; the write is accepted.
- Credit: a registered pulse one cycle after each accepted pop. credit_vc_id_o = index of the popped one-hot; at most one credit per cycle.
- Flit_vc_id_i >= VC_NUM: the write is ignored.
- Read select not one-hot (zero or multiple bits) with enable=1: no pop; treated as underflow.
- Reset asserted mid-traffic: next cycle all VCs are empty, no credit is issued, and in-flight flits are discarded.

Optional Feature:
- Macro: VC_BUF_ERR_CHECK_EN.
- Defined:
  - overflow_err_o sets on any write to a full VC (without a same-cycle pop); the flit is dropped.
  - underflow_err_o sets on an enabled read of an empty VC or a non-one-hot select.
  - Both flags are sticky until reset.
- Undefined: both flags are tied to 0 and the detection logic is absent. Drop and ignore behaviour is unchanged.

Decomposition:
- rvh_noc_pkg holds:
  - flit header width (33).
  - QoS_Value_Width (4), QoS field at [3:0].
  - look-ahead routing field at [6:4].
  - OUTPUT_PORT_NUMBER (6).
- Sub-module vc_fifo: single-VC circular FIFO with depth parameter, push/pop, head, count, full/empty. Instantiated VC_NUM times via generate.
- Top level holds write demux, credit register and error flags.

Test Plan:
- Reset, then write flit 0x0_0000_0015 to VC2 -> next cycle head_vld=4'b0100, head slice 2 = 0x15, occupancy[2]=1.
- Write 4 flits to VC1 (A,B,C,D), then a 5th flit E to VC1 -> E dropped, occupancy[1]=4, overflow_err_o=1 with the macro (0 without). Four pops to VC1 return A,B,C,D in order.
- Pop VC1 (oh=4'b0010) at cycle t -> credit_vld_o=1 and credit_vc_id_o=1 at t+1; occupancy[1] decrements.
- VC0 full (4 flits), simultaneous write to VC0 and pop of VC0 -> write accepted, occupancy stays 4, no overflow, credit for VC0 next cycle.
- Read enable with oh=4'b0000, then with oh=4'b1000 while VC3 is empty -> no pointer change, no credit, underflow_err_o=1 with the macro.
- 6 writes to VC3 interleaved with pops, exercising wrap -> order preserved; assert rstn mid-stream -> next cycle head_vld=0, occupancy all 0, credit_vld_o=0.
